sample_page_packer: RTL
=======================

Name: sample_page_packer

Overview:
- Sits between the SPI ADC controller and the I2C EEPROM controller.
- Packs single ADC sample words into 512-bit EEPROM page images and hands each full page to the EEPROM writer over a valid/ready handshake.
- Double-buffered: one page fills while the previous page waits for the writer, so the ADC sample rate is decoupled from I2C write latency.
- Dropped samples are counted and flagged.

Parameters:
- SAMPLE_W, 12, ADC sample word width; must be <= SLOT_W.
- SLOT_W, 16, bits per page slot; each sample is zero-extended to this width.
- PAGE_BITS, 512, page image width; PAGE_BITS/SLOT_W slots per page (32 at defaults).
- PAD_WORD, 16'hFFFF, value written into unused slots on flush (erased-EEPROM value).

Ports:
- CLK_50MHz  in  1  system clock; all logic is on its rising edge.
- RESET  in  1  reset, asynchronous, active-low (0 = reset).
- sample_word  in  SAMPLE_W  ADC result from the SPI controller.
- sample_valid  in  1  one-cycle strobe; sample_word is valid in the same cycle.
- flush  in  1  one-cycle strobe; emits the current partial page, padded.
- page_data  out  PAGE_BITS  hold-buffer page image; slot k occupies bits [k*SLOT_W +: SLOT_W].
- page_valid  out  1  the hold buffer contains a page.
- page_ready  in  1  the EEPROM writer accepts the page when page_valid && page_ready.
- cache_index  out  5  next fill slot, 0..31.
- overflow  out  1  sticky; set on the first dropped sample.
- drop_count  out  16  count of dropped samples, saturates at 16'hFFFF.
- page_count  out  16  count of pages accepted by the writer, wraps.

Behaviour:
- Reset: page_data=0, page_valid=0, cache_index=0, overflow=0, drop_count=0, page_count=0, fill buffer=0, pending=0. Reset acts asynchronously in any state, including mid-fill or mid-handshake; partial data is discarded.
- Fill: on sample_valid with pending=0, slot[cache_index] <= zero-extended sample_word and cache_index increments.
- The write into slot 31 completes a page. On the next edge the fill buffer transfers to the hold buffer if the hold buffer is free; otherwise pending=1.
- The hold buffer is free when page_valid=0, or when the hold page is accepted in the same cycle (page_valid && page_ready).
- Transfer: page_data <= fill buffer, page_valid <= 1, cache_index <= 0, fill buffer <= 0, pending <= 0.
- Pending (fill buffer full, hold buffer occupied):
  - sample_valid is dropped; overflow <= 1; drop_count increments with saturation.
  - The transfer happens in the cycle the hold page is accepted, so there is zero bubble.
- Handshake:
  - page_valid stays high and page_data stays stable until accepted.
  - On accept with no transfer in the same cycle: page_valid <= 0.
  - page_count increments on every accept.
- Latency: the sample written into slot 31 at edge N appears on page_data with page_valid=1 at edge N+1 when the hold buffer is free.
- Flush:
  - With cache_index>0 and pending=0: slots cache_index..31 <= PAD_WORD, and the page is treated as complete (same transfer rules).
  - With cache_index=0: no effect.
  - With pending=1: ignored.
- sample_valid and flush in the same cycle: the sample is written first, then the padding starts from the incremented index. If that sample fills slot 31, the flush is a no-op.
- One state variable per buffer: fill in {FILLING, PENDING}, hold in {EMPTY, FULL}.

Decomposition:
- Shared package `datalogger_pkg`:
  - constants PAGE_BITS, SLOT_W, SLOTS_PER_PAGE, IDX_W.
  - PAD_WORD.
  - fill-state enum {FILLING, PENDING}.
- One sub-module: `sat_counter` (parameterised width, increment enable, saturation on/off), used for drop_count (saturating) and page_count (wrapping).

Test Plan:
- 32 samples 12'h000..12'h01F with page_ready=1 -> page_valid high one cycle after the 32nd sample; page_data slot k = 16'h00k; page_count=1; cache_index=0.
- page_ready=0, 64 samples -> first page held stable; second page pending; a 65th sample is dropped with overflow=1 and drop_count=1. Raise page_ready for one cycle -> page 2 appears next cycle with no gap; page_count=1.
- 5 samples 12'hABC then flush -> slots 0..4 = 16'h0ABC, slots 5..31 = 16'hFFFF, page_valid=1.
- Flush with cache_index=0 -> no page_valid, no state change. Flush together with the 32nd sample -> exactly one page emitted.
- Drive pending plus continuous samples for 70000 cycles -> drop_count saturates at 16'hFFFF, overflow stays 1.
- Assert RESET (drive to 0) asynchronously mid-fill at cache_index=17 and during page_valid=1 -> all outputs return to reset values immediately; the next 32 samples form a clean page.

Source files
------------

// File: rtl/datalogger_pkg.sv
// Shared constants and state types for the sample-to-EEPROM-page datalogger path.
package datalogger_pkg;
  localparam int PAGE_BITS = 512;
  localparam int SLOT_W = 16;
  localparam int SLOTS_PER_PAGE = PAGE_BITS / SLOT_W;
  localparam int IDX_W = $clog2(SLOTS_PER_PAGE);
  localparam logic [SLOT_W-1:0] PAD_WORD = 16'hFFFF;

  typedef enum logic {FILLING = 1'b0, PENDING = 1'b1} fill_state_t;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} hold_state_t;
endpackage

// File: rtl/sat_counter.sv
// Up-counter with enable; either saturates at all-ones or wraps.
module sat_counter #(
  parameter int W = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && !(SATURATE && (&count))) begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/sample_page_packer.sv
// Packs ADC samples into EEPROM page images; a fill buffer feeds a hold buffer
// that is offered to the EEPROM writer.
module sample_page_packer
  import datalogger_pkg::*;
#(
  parameter int SAMPLE_W = 12,
  parameter int SLOT_W = datalogger_pkg::SLOT_W,
  parameter int PAGE_BITS = datalogger_pkg::PAGE_BITS,
  parameter logic [SLOT_W-1:0] PAD_WORD = datalogger_pkg::PAD_WORD
) (
  input  logic                                   CLK_50MHz,
  input  logic                                   RESET,
  input  logic [SAMPLE_W-1:0]                    sample_word,
  input  logic                                   sample_valid,
  input  logic                                   flush,
  output logic [PAGE_BITS-1:0]                   page_data,
  output logic                                   page_valid,
  input  logic                                   page_ready,
  output logic [$clog2(PAGE_BITS/SLOT_W)-1:0]    cache_index,
  output logic                                   overflow,
  output logic [15:0]                            drop_count,
  output logic [15:0]                            page_count,
  output fill_state_t                            fill_state,
  output hold_state_t                            hold_state
);
  localparam int SLOTS = PAGE_BITS / SLOT_W;
  localparam int IDX_W = $clog2(SLOTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOTS - 1);

  // Handshake: a page moves to the writer on any rising edge where
  // page_valid && page_ready; page_data is held stable while page_valid is high.
  logic [PAGE_BITS-1:0] fill_buf, buf_wr, buf_next;
  logic [IDX_W-1:0]     idx_wr;
  logic hold_free, accept, transfer, drop, page_done, do_flush;

  always_comb begin
    hold_free = (hold_state == EMPTY) || page_ready;
    accept    = (hold_state == FULL) && page_ready;
    transfer  = (fill_state == PENDING) && hold_free;
    drop      = (fill_state == PENDING) && !hold_free && sample_valid;
    // A transfer empties the fill buffer, so a sample in that cycle lands in slot 0.
    buf_wr    = transfer ? '0 : fill_buf;
    idx_wr    = transfer ? '0 : cache_index;
    page_done = 1'b0;
    if (sample_valid && ((fill_state == FILLING) || transfer)) begin
      buf_wr[int'(idx_wr)*SLOT_W +: SLOT_W] = SLOT_W'(sample_word);
      page_done = (idx_wr == LAST_IDX);
      idx_wr    = page_done ? '0 : idx_wr + 1'b1;
    end
    do_flush = flush && (fill_state == FILLING) && !page_done && (idx_wr != '0);
    buf_next = buf_wr;
    if (do_flush) begin
      for (int k = 0; k < SLOTS; k++) begin
        if (k >= int'(idx_wr)) buf_next[k*SLOT_W +: SLOT_W] = PAD_WORD;
      end
    end
  end

  always_ff @(posedge CLK_50MHz or negedge RESET) begin
    if (!RESET) begin
      fill_buf    <= '0;
      cache_index <= '0;
      fill_state  <= FILLING;
      hold_state  <= EMPTY;
      page_data   <= '0;
      overflow    <= 1'b0;
    end else begin
      fill_buf    <= buf_next;
      cache_index <= do_flush ? '0 : idx_wr;
      if (page_done || do_flush) fill_state <= PENDING;
      else if (transfer)         fill_state <= FILLING;
      if (transfer) begin
        page_data  <= fill_buf;
        hold_state <= FULL;
      end else if (accept) begin
        hold_state <= EMPTY;
      end
      if (drop) overflow <= 1'b1;
    end
  end

  assign page_valid = (hold_state == FULL);

  sat_counter #(.W(16), .SATURATE(1'b1)) u_drop_count (
    .clk(CLK_50MHz), .rst_n(RESET), .en(drop), .count(drop_count)
  );

  sat_counter #(.W(16), .SATURATE(1'b0)) u_page_count (
    .clk(CLK_50MHz), .rst_n(RESET), .en(accept), .count(page_count)
  );
endmodule
